// File: rtl/effect_chain_scheduler.sv
// rtl/effect_chain_scheduler.sv - routes each stereo frame through the enabled effect slots, one slot at a time.
// Define EFF_WATCHDOG_EN to bypass a slot that stays silent for TIMEOUT cycles.
module effect_chain_scheduler #(
  parameter int D_WIDTH     = 24,
  parameter int MEM_D_WIDTH = 16,
  parameter int N_EFF       = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_EFF-1:0]             i_sw,
  input  logic [D_WIDTH-1:0]           i_l_data,
  input  logic [D_WIDTH-1:0]           i_r_data,
  input  logic                         i_dv,
  output logic [MEM_D_WIDTH-1:0]       o_eff_data,
  output logic [N_EFF-1:0]             o_eff_sel,
  output logic                         o_eff_dv,
  input  logic [N_EFF*MEM_D_WIDTH-1:0] i_eff_data,
  input  logic [N_EFF-1:0]             i_eff_dv,
  output logic [D_WIDTH-1:0]           o_l_data_tx,
  output logic [D_WIDTH-1:0]           o_r_data_tx,
  output logic                         o_tx_dv,
  output logic                         o_busy,
  output logic                         o_overrun,
  output logic                         o_timeout
);

  localparam int IDX_W = $clog2(N_EFF + 1);
  localparam int PAD_W = D_WIDTH - MEM_D_WIDTH;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SCAN   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  logic [2:0]             r_state;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_ch;
  logic [N_EFF-1:0]       r_en;
  logic [MEM_D_WIDTH-1:0] r_sample;
  logic [MEM_D_WIDTH-1:0] r_r_in;
  logic [MEM_D_WIDTH-1:0] r_l_res;
  logic [MEM_D_WIDTH-1:0] r_eff_data;
  logic [N_EFF-1:0]       r_eff_sel;
  logic                   r_eff_dv;
  logic [D_WIDTH-1:0]     r_l_tx;
  logic [D_WIDTH-1:0]     r_r_tx;
  logic                   r_tx_dv;
  logic                   r_overrun;

  logic                   w_idx_end;
  logic                   w_en_cur;
  logic                   w_rsp_dv;
  logic [MEM_D_WIDTH-1:0] w_rsp_data;
  logic [N_EFF-1:0]       w_sel;
  logic                   w_unused_pad;

`ifdef EFF_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0]        r_wd_cnt;
  logic                   r_timeout;
  logic                   w_wd_expired;

  assign w_wd_expired = (r_wd_cnt == WD_W'(TIMEOUT - 1));
  assign o_timeout    = r_timeout;
`else
  logic                   w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT == 0);
  assign o_timeout        = 1'b0;
`endif

  // Only the upper MEM_D_WIDTH bits of each sample ever reach an effect.
  assign w_unused_pad = ^{i_l_data[PAD_W-1:0], i_r_data[PAD_W-1:0]};
  assign w_idx_end    = (r_idx == IDX_W'(N_EFF));

  always_comb begin
    w_en_cur   = 1'b0;
    w_rsp_dv   = 1'b0;
    w_rsp_data = '0;
    w_sel      = '0;
    for (int k = 0; k < N_EFF; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_en_cur   = r_en[k];
        w_rsp_dv   = i_eff_dv[k];
        w_rsp_data = i_eff_data[k*MEM_D_WIDTH +: MEM_D_WIDTH];
        w_sel[k]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_ch       <= 1'b0;
      r_en       <= '0;
      r_sample   <= '0;
      r_r_in     <= '0;
      r_l_res    <= '0;
      r_eff_data <= '0;
      r_eff_sel  <= '0;
      r_eff_dv   <= 1'b0;
      r_l_tx     <= '0;
      r_r_tx     <= '0;
      r_tx_dv    <= 1'b0;
      r_overrun  <= 1'b0;
`ifdef EFF_WATCHDOG_EN
      r_wd_cnt   <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_eff_dv  <= 1'b0;
      r_eff_sel <= '0;
      r_tx_dv   <= 1'b0;
      r_overrun <= i_dv && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (i_dv) begin
            r_sample <= i_l_data[D_WIDTH-1 -: MEM_D_WIDTH];
            r_r_in   <= i_r_data[D_WIDTH-1 -: MEM_D_WIDTH];
            r_en     <= i_sw;
            r_ch     <= 1'b0;
            r_idx    <= '0;
            r_state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_idx_end) begin
            if (!r_ch) begin
              r_l_res  <= r_sample;
              r_sample <= r_r_in;
              r_ch     <= 1'b1;
              r_idx    <= '0;
            end else begin
              r_state <= S_COMMIT;
            end
          end else if (w_en_cur) begin
            // Request outputs are registered so they are high exactly during ISSUE.
            r_eff_dv   <= 1'b1;
            r_eff_data <= r_sample;
            r_eff_sel  <= w_sel;
            r_state    <= S_ISSUE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_ISSUE: begin
`ifdef EFF_WATCHDOG_EN
          r_wd_cnt <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_rsp_dv) begin
            r_sample <= w_rsp_data;
            r_idx    <= r_idx + IDX_W'(1);
            r_state  <= S_SCAN;
`ifdef EFF_WATCHDOG_EN
          end else if (w_wd_expired) begin
            r_timeout <= 1'b1;
            r_idx     <= r_idx + IDX_W'(1);
            r_state   <= S_SCAN;
          end else begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
`endif
          end
        end
        S_COMMIT: begin
          r_l_tx  <= {r_l_res, {PAD_W{1'b0}}};
          r_r_tx  <= {r_sample, {PAD_W{1'b0}}};
          r_tx_dv <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_eff_data  = r_eff_data;
  assign o_eff_sel   = r_eff_sel;
  assign o_eff_dv    = r_eff_dv;
  assign o_l_data_tx = r_l_tx;
  assign o_r_data_tx = r_r_tx;
  assign o_tx_dv     = r_tx_dv;
  assign o_busy      = (r_state != S_IDLE);
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_effect_chain_scheduler.sv
// tb/tb_effect_chain_scheduler.sv - scoreboard bench for effect_chain_scheduler with behavioural effect slots.
module tb_effect_chain_scheduler;

  localparam int D_WIDTH     = 24;
  localparam int MEM_D_WIDTH = 16;
  localparam int N_EFF       = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  i_sw = '0;
  logic [23:0] i_l_data = '0;
  logic [23:0] i_r_data = '0;
  logic        i_dv = 1'b0;
  logic [15:0] o_eff_data;
  logic [1:0]  o_eff_sel;
  logic        o_eff_dv;
  logic [31:0] i_eff_data = '0;
  logic [1:0]  i_eff_dv = '0;
  logic [23:0] o_l_data_tx;
  logic [23:0] o_r_data_tx;
  logic        o_tx_dv;
  logic        o_busy;
  logic        o_overrun;
  logic        o_timeout;

  effect_chain_scheduler #(
    .D_WIDTH(D_WIDTH), .MEM_D_WIDTH(MEM_D_WIDTH), .N_EFF(N_EFF), .TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset), .i_sw(i_sw), .i_l_data(i_l_data), .i_r_data(i_r_data),
    .i_dv(i_dv), .o_eff_data(o_eff_data), .o_eff_sel(o_eff_sel), .o_eff_dv(o_eff_dv),
    .i_eff_data(i_eff_data), .i_eff_dv(i_eff_dv), .o_l_data_tx(o_l_data_tx),
    .o_r_data_tx(o_r_data_tx), .o_tx_dv(o_tx_dv), .o_busy(o_busy),
    .o_overrun(o_overrun), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] data;
  } req_t;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    int          start;
    int          lat;
  } tx_t;

  req_t req_q[$];
  tx_t  tx_q[$];
  req_t m_req;
  tx_t  m_tx;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_ovr = 0;
  int   ovr0;
  logic [1:0] model_en = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a request or a frame.
  always @(negedge clk) begin
    if (!reset) begin
      if (o_overrun) n_ovr++;
      if (o_eff_dv) begin
        if (req_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_req: got sel %0h data %0h expected none", o_eff_sel, o_eff_data);
        end else begin
          m_req = req_q.pop_front();
          chk("req_sel", 32'(o_eff_sel), 32'(m_req.sel));
          chk("req_data", 32'(o_eff_data), 32'(m_req.data));
        end
      end
      if (o_tx_dv) begin
        if (tx_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_tx: got l %0h r %0h expected none", o_l_data_tx, o_r_data_tx);
        end else begin
          m_tx = tx_q.pop_front();
          chk("tx_l", 32'(o_l_data_tx), 32'(m_tx.l));
          chk("tx_r", 32'(o_r_data_tx), 32'(m_tx.r));
          chk("tx_latency", 32'(cyc - m_tx.start + 1), 32'(m_tx.lat));
        end
      end
    end
  end

  // Effect slots: slot 0 returns x+1, slot 1 returns x<<1, one cycle later than the earliest possible.
  int          pend = 0;
  int          pend_slot = 0;
  logic [15:0] pend_val = '0;

  always @(negedge clk) begin
    i_eff_dv = '0;
    if (reset) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          i_eff_dv[pend_slot] = 1'b1;
          i_eff_data[pend_slot*16 +: 16] = pend_val;
        end
      end
      if (o_eff_dv) begin
        pend_slot = o_eff_sel[1] ? 1 : 0;
        if (model_en[pend_slot]) begin
          pend     = 2;
          pend_val = o_eff_sel[1] ? (o_eff_data << 1) : (o_eff_data + 16'd1);
        end
      end
    end
  end

  task automatic push_req(input logic [1:0] sel, input logic [15:0] data);
    req_t e;
    e.sel  = sel;
    e.data = data;
    req_q.push_back(e);
  endtask

  task automatic send(input logic [1:0] sw, input logic [23:0] l, input logic [23:0] r,
                      input logic [23:0] el, input logic [23:0] er, input int lat, input bit push);
    tx_t e;
    @(negedge clk);
    i_sw     = sw;
    i_l_data = l;
    i_r_data = r;
    i_dv     = 1'b1;
    if (push) begin
      e.l     = el;
      e.r     = er;
      e.start = cyc + 1;
      e.lat   = lat;
      tx_q.push_back(e);
    end
    @(negedge clk);
    i_dv = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((tx_q.size() != 0 || o_busy) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      n_cmp++; n_err++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", k);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_eff_dv", 32'(o_eff_dv), 32'd0);
    chk("rst_tx_dv", 32'(o_tx_dv), 32'd0);
    chk("rst_l_tx", 32'(o_l_data_tx), 32'd0);
    chk("rst_overrun", 32'(o_overrun), 32'd0);
    chk("rst_timeout", 32'(o_timeout), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // No slots: pure truncate/pad, 8-edge latency.
    send(2'b00, 24'h123456, 24'hABCDEF, 24'h123400, 24'hABCD00, 8, 1'b1);
    wait_idle();

    // Slot 0 only, both channels visit it.
    model_en = 2'b01;
    push_req(2'b01, 16'h1234);
    push_req(2'b01, 16'hABCD);
    send(2'b01, 24'h123456, 24'hABCDEF, 24'h123500, 24'hABCE00, 14, 1'b1);
    wait_idle();

    // Both slots, chained in order.
    model_en = 2'b11;
    push_req(2'b01, 16'h0001);
    push_req(2'b10, 16'h0002);
    push_req(2'b01, 16'h00FF);
    push_req(2'b10, 16'h0100);
    send(2'b11, 24'h000100, 24'h00FF00, 24'h000400, 24'h020000, 20, 1'b1);
    wait_idle();

    // Second frame 3 cycles into the first is dropped.
    ovr0 = n_ovr;
    send(2'b00, 24'h111111, 24'h222222, 24'h111100, 24'h222200, 8, 1'b1);
    repeat (1) @(negedge clk);
    send(2'b00, 24'h333333, 24'h444444, 24'h0, 24'h0, 0, 1'b0);
    wait_idle();
    chk("overrun_mid", 32'(n_ovr - ovr0), 32'd1);

    // Frame arriving exactly on the COMMIT cycle is also dropped.
    ovr0 = n_ovr;
    send(2'b00, 24'h777777, 24'h888888, 24'h777700, 24'h888800, 8, 1'b1);
    repeat (5) @(negedge clk);
    send(2'b00, 24'h999999, 24'hAAAAAA, 24'h0, 24'h0, 0, 1'b0);
    wait_idle();
    chk("overrun_commit", 32'(n_ovr - ovr0), 32'd1);

    // Reset while waiting on slot 0.
    model_en = 2'b01;
    push_req(2'b01, 16'h5555);
    send(2'b01, 24'h555555, 24'h666666, 24'h0, 24'h0, 0, 1'b0);
    begin
      int k = 0;
      while (!o_eff_dv && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("reset_req_seen", 32'(o_eff_dv), 32'd1);
    end
    @(negedge clk);
    chk("pre_reset_busy", 32'(o_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_eff_dv", 32'(o_eff_dv), 32'd0);
    chk("mid_rst_eff_sel", 32'(o_eff_sel), 32'd0);
    chk("mid_rst_l_tx", 32'(o_l_data_tx), 32'd0);
    chk("mid_rst_r_tx", 32'(o_r_data_tx), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    send(2'b00, 24'hFEDCBA, 24'h010203, 24'hFEDC00, 24'h010200, 8, 1'b1);
    wait_idle();

`ifdef EFF_WATCHDOG_EN
    // Silent slot 0 is bypassed after 4 WAIT cycles per channel.
    model_en = 2'b00;
    push_req(2'b01, 16'h1234);
    push_req(2'b01, 16'hABCD);
    send(2'b01, 24'h123456, 24'hABCDEF, 24'h123400, 24'hABCD00, 18, 1'b1);
    wait_idle();
    chk("timeout_set", 32'(o_timeout), 32'd1);
    repeat (5) @(negedge clk);
    chk("timeout_sticky", 32'(o_timeout), 32'd1);
`else
    chk("timeout_tied", 32'(o_timeout), 32'd0);
`endif

    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    chk("tx_q_empty", 32'(tx_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/effect_chain_scheduler.md
Name: effect_chain_scheduler

Overview:
- Sequences each stereo frame from io_module through the switch-enabled effect slots, one slot at a time, and returns the processed frame for transmit.
- Runs in the master_clk domain. Sits between io_module's l/r_data_rx/l/r_data_tx and the effect modules.
- Shares a single effect request bus between both channels and all slots. Effects see only the upper MEM_D_WIDTH bits of each sample.

Parameters:
- D_WIDTH, 24, I2S sample width.
- MEM_D_WIDTH, 16, effect/memory sample width; the lower D_WIDTH-MEM_D_WIDTH bits are discarded.
- N_EFF, 2, number of effect slots; slot 0 is processed first.
- TIMEOUT, 255, watchdog limit in clk cycles for one effect response (used only when EFF_WATCHDOG_EN is defined).

Ports:
- clk  in  1  master clock (master_clk).
- reset  in  1  asynchronous, active-high reset.
- i_sw  in  N_EFF  slot enables (bit k enables slot k).
- i_l_data  in  D_WIDTH  left sample from io_module.
- i_r_data  in  D_WIDTH  right sample from io_module.
- i_dv  in  1  one-cycle pulse per frame; both i_l_data and i_r_data are valid with it.
- o_eff_data  out  MEM_D_WIDTH  sample sent to the selected slot.
- o_eff_sel  out  N_EFF  one-hot slot select; valid only together with o_eff_dv.
- o_eff_dv  out  1  one-cycle request strobe to the selected slot.
- i_eff_data  in  N_EFF*MEM_D_WIDTH  slot results; slot k occupies bits [k*MEM_D_WIDTH +: MEM_D_WIDTH].
- i_eff_dv  in  N_EFF  per-slot result valid.
- o_l_data_tx  out  D_WIDTH  processed left sample to io_module.
- o_r_data_tx  out  D_WIDTH  processed right sample to io_module.
- o_tx_dv  out  1  one-cycle pulse when o_l/r_data_tx are updated.
- o_busy  out  1  high whenever the FSM is not in IDLE.
- o_overrun  out  1  one-cycle pulse when a frame is dropped.
- o_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (asynchronous, any state, including mid-frame):
  - FSM goes to IDLE.
  - All outputs go to 0.
  - Any in-flight frame is discarded; no o_tx_dv is issued for it.
- IDLE, on i_dv:
  - Latch L = i_l_data[D_WIDTH-1 -: MEM_D_WIDTH] and R likewise from i_r_data.
  - Latch en = i_sw. Switch changes mid-frame have no effect until the next frame.
  - Set ch=0, idx=0, sample=L. Go to SCAN.
- SCAN, in priority order:
  - idx==N_EFF and ch==0: store the left result, ch=1, sample=R, idx=0, stay in SCAN.
  - idx==N_EFF and ch==1: go to COMMIT.
  - en[idx]==1: go to ISSUE.
  - Otherwise: idx++, stay in SCAN.
- ISSUE: for exactly one cycle drive o_eff_dv=1, o_eff_data=sample, o_eff_sel=1<<idx. Go to WAIT.
- WAIT:
  - On i_eff_dv[idx]: sample = slot idx slice of i_eff_data, idx++, go to SCAN.
  - i_eff_dv bits for other slots are ignored.
  - i_eff_dv[idx] high during the ISSUE cycle is ignored; the effect must respond in WAIT.
- COMMIT:
  - Register o_l_data_tx = {left result, (D_WIDTH-MEM_D_WIDTH)'b0} and o_r_data_tx likewise.
  - o_tx_dv=1 for the next cycle. Go to IDLE.
  - o_l/r_data_tx hold between commits.
- Latency, from the edge that samples i_dv to o_tx_dv high:
  - 2*(N_EFF+1)+2 edges with no slots enabled (8 for N_EFF=2).
  - Each enabled slot adds 2 edges per channel, plus the extra WAIT cycles that slot takes.
- Overrun:
  - i_dv while the FSM is not in IDLE (including the COMMIT cycle) drops that frame and pulses o_overrun for one cycle.
  - The in-flight frame continues unaffected.
- o_busy = (state != IDLE), registered with the state.
- No arithmetic is performed. Results pass through unchanged apart from truncation and zero-padding.

Optional Feature:
- Macro EFF_WATCHDOG_EN.
- Defined:
  - A counter starts at 0 on WAIT entry and increments each WAIT cycle.
  - If it reaches TIMEOUT with no i_eff_dv[idx], sample is left unchanged (slot bypassed), idx++, go to SCAN, and o_timeout is set.
  - o_timeout stays high until reset.
- Undefined: WAIT holds indefinitely and o_timeout is tied to 0.

Test Plan:
- N_EFF=2, i_sw=2'b00, i_l_data=24'h123456, i_r_data=24'hABCDEF, i_dv pulse -> o_tx_dv exactly 8 edges later; o_l_data_tx=24'h123400, o_r_data_tx=24'hABCD00; o_eff_dv never asserts.
- i_sw=2'b01, slot-0 model returns input+1 one cycle after the request -> two requests, both with o_eff_sel=2'b01: first o_eff_data=16'h1234, then 16'hABCD. Outputs 24'h123500 / 24'hABCE00; o_tx_dv at edge 14.
- i_sw=2'b11, slot 0 returns x+1 and slot 1 returns x<<1, L=24'h000100 -> requests in order slot0 (0x0001), slot1 (0x0002), then the R pair. o_l_data_tx=24'h000400.
- A second i_dv 3 cycles after the first, i_sw=2'b00 -> one o_overrun pulse; a single o_tx_dv carrying the first frame's data only.
- Reset asserted while in WAIT -> all outputs 0 immediately; no o_tx_dv afterwards. Next i_dv after release is processed normally.
- EFF_WATCHDOG_EN defined, TIMEOUT=4, slot 0 silent, i_sw=2'b01 -> after 4 WAIT cycles the slot is bypassed and o_timeout=1 (sticky). Outputs equal the truncated inputs; o_tx_dv still asserts.
